apb_cmd_master: RTL
===================

Name: apb_cmd_master

Overview:
- APB4 requester that sits directly upstream of the APB memory slave.
- Accepts single read/write commands on a valid/ready command port.
- Runs each command as one APB transfer: SETUP phase, then ACCESS phase with wait states.
- Returns read data, slave error and timeout status on a valid/ready response port, with one command outstanding at a time.

Parameters:
- ADDR_WIDTH, 8, width of PADDR and cmd_addr
- DATA_WIDTH, 32, width of PWDATA/PRDATA; must be a multiple of 8
- STRB_WIDTH, DATA_WIDTH/8, width of PSTRB and cmd_strb
- TIMEOUT_CYCLES, 16, maximum number of ACCESS cycles before the transfer is abandoned; range 1..255

Ports:
- PCLK  in  1  APB clock; all logic on its rising edge
- PRESETn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high together with cmd_valid
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_WIDTH  transfer address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_strb  in  STRB_WIDTH  byte lane enables for writes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when high together with rsp_valid
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes, errors and timeouts
- rsp_err  out  1  PSLVERR was sampled high at completion
- rsp_timeout  out  1  transfer abandoned after TIMEOUT_CYCLES
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  ADDR_WIDTH  APB address
- PWDATA  out  DATA_WIDTH  APB write data
- PSTRB  out  STRB_WIDTH  APB write strobes
- PREADY, PSLVERR  in  1  APB slave response
- PRDATA  in  DATA_WIDTH  APB read data

Behaviour:
- Reset (asynchronous, PRESETn low):
  - State goes to IDLE.
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp_valid, rsp_rdata, rsp_err, rsp_timeout all 0.
  - Wait counter 0.
- Reset mid-transfer: the transfer is dropped, no response is produced, and PSEL falls asynchronously.
- States: IDLE, SETUP, ACCESS. All APB outputs are registered.
- cmd_ready:
  - Equals 1 only when state==IDLE and (rsp_valid==0 or rsp_ready==1).
  - Combinational from state, rsp_valid and rsp_ready only; it never depends on cmd_valid.
- Command acceptance (IDLE, handshake at edge N):
  - Latch addr, write, wdata and strb onto PADDR, PWRITE, PWDATA, PSTRB.
  - For reads, PSTRB is forced to 0 and PWDATA to 0.
  - Set PSEL=1, PENABLE=0 and go to SETUP.
- SETUP (exactly one cycle): set PENABLE=1, clear the wait counter, go to ACCESS.
- ACCESS:
  - PADDR, PWRITE, PWDATA and PSTRB are held stable.
  - PREADY=1 completes the transfer at that edge:
    - PSEL=0 and PENABLE=0; go to IDLE.
    - rsp_valid=1.
    - rsp_err=PSLVERR.
    - rsp_rdata = PRDATA for a read with PSLVERR=0, otherwise 0.
    - rsp_timeout=0.
  - PREADY=0 increments the wait counter. When the counter reaches TIMEOUT_CYCLES-1 and PREADY is still 0, the transfer is abandoned:
    - PSEL=0, PENABLE=0, go to IDLE.
    - rsp_valid=1, rsp_timeout=1, rsp_err=0, rsp_rdata=0.
  - If PREADY=1 arrives on the timeout cycle, completion wins and no timeout is reported.
- Response handling:
  - rsp_* are held stable while rsp_valid=1 and rsp_ready=0.
  - rsp_valid clears on the rsp_ready handshake unless a new response is loaded on the same edge; that cannot happen, because only one command is outstanding.
- Throughput and latency:
  - Minimum transfer is 3 cycles: IDLE accept, SETUP, ACCESS with PREADY=1.
  - rsp_valid rises on the edge at which PREADY is sampled.
  - A new command can be accepted in the first IDLE cycle after completion, provided rsp_ready=1 or the response has already drained.
- APB rules: PSEL never drops during ACCESS without completion or timeout, and PENABLE is never high without PSEL.

Test Plan:
- Read from a zero-wait slave, addr 0x24 → PSEL/PENABLE pattern 10,11. PRDATA=0xCAFE_F00D sampled at the first ACCESS edge. rsp_valid next cycle with rsp_rdata=0xCAFE_F00D and rsp_err=0.
- Write to 0x40 with data 0xA5A5_1234 and strb 4'b0101, against the memory slave with 4-cycle write latency → ACCESS lasts 4 cycles. Read-back returns 0x00A5_0034 from a cleared memory.
- Write to 0x05, a read-only region where the slave asserts PSLVERR → rsp_err=1, rsp_rdata=0, rsp_timeout=0.
- Slave holds PREADY=0 with TIMEOUT_CYCLES=4 → PSEL drops after 4 ACCESS cycles, rsp_timeout=1, and the next command is accepted normally.
- Back-to-back reads with rsp_ready held 0 for 3 cycles → cmd_ready stays 0 and rsp_* stay stable. Second transfer's SETUP starts one cycle after the rsp handshake.
- PRESETn asserted during ACCESS → all outputs 0 immediately, no rsp_valid after release, next command completes correctly.

Source files
------------

// File: rtl/apb_cmd_master_if.sv
// apb_cmd_master_if: command/response handshake plus APB4 requester bus.
// master is the requester's view, slave is the environment (command source and APB slave).
interface apb_cmd_master_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [STRB_WIDTH-1:0] cmd_strb;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [STRB_WIDTH-1:0] PSTRB;
  logic                  PREADY;
  logic                  PSLVERR;
  logic [DATA_WIDTH-1:0] PRDATA;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
           PREADY, PSLVERR, PRDATA,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
           PREADY, PSLVERR, PRDATA,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
  );
endinterface

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: runs one valid/ready command at a time as an APB4 transfer
// (SETUP then ACCESS with wait states and timeout) and returns a response.
module apb_cmd_master #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic PCLK,
  input logic PRESETn,
  apb_cmd_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  state_t state, state_nxt;
  logic [7:0] wait_cnt;
  logic accept, done, expire;
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = (state == IDLE)   ? (accept ? SETUP : IDLE) :
                (state == SETUP)  ? ACCESS :
                (state == ACCESS && !done && !expire) ? ACCESS : IDLE;
  end
  // cmd_ready depends only on state and the response port, never on cmd_valid
  always_comb begin
    bus.cmd_ready = (state == IDLE) && (!bus.rsp_valid || bus.rsp_ready);
    accept        = bus.cmd_ready && bus.cmd_valid;
    done          = (state == ACCESS) && bus.PREADY;
    expire        = (state == ACCESS) && !bus.PREADY && (wait_cnt == TO_LAST);
  end
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      bus.PSEL        <= 1'b0;
      bus.PENABLE     <= 1'b0;
      bus.PWRITE      <= 1'b0;
      bus.PADDR       <= '0;
      bus.PWDATA      <= '0;
      bus.PSTRB       <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.rsp_err     <= 1'b0;
      bus.rsp_timeout <= 1'b0;
      wait_cnt        <= '0;
    end else begin
      if (accept) begin
        bus.PSEL    <= 1'b1;
        bus.PENABLE <= 1'b0;
        bus.PWRITE  <= bus.cmd_write;
        bus.PADDR   <= ADDR_WIDTH'(bus.cmd_addr);
        bus.PWDATA  <= bus.cmd_write ? bus.cmd_wdata : DATA_WIDTH'(0);
        bus.PSTRB   <= bus.cmd_write ? bus.cmd_strb : STRB_WIDTH'(0);
      end
      if (state == SETUP) begin
        bus.PENABLE <= 1'b1;
        wait_cnt    <= '0;
      end
      if (state == ACCESS && !bus.PREADY && !expire) wait_cnt <= wait_cnt + 8'd1;
      // completion wins over timeout when PREADY lands on the last allowed cycle
      if (done || expire) begin
        bus.PSEL        <= 1'b0;
        bus.PENABLE     <= 1'b0;
        bus.rsp_valid   <= 1'b1;
        bus.rsp_err     <= done && bus.PSLVERR;
        bus.rsp_timeout <= expire;
        bus.rsp_rdata   <= (done && !bus.PWRITE && !bus.PSLVERR) ? bus.PRDATA : DATA_WIDTH'(0);
      end else if (bus.rsp_ready) begin
        bus.rsp_valid <= 1'b0;
      end
    end
  end
endmodule
